// File: rtl/eq_pkg.sv
// Shared defaults and FSM state type for the equaliser MAC datapath.
package eq_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_COEFF_W   = 16;
  localparam int unsigned DEF_ACC_W     = 40;
  localparam int unsigned DEF_TAPS      = 64;
  localparam int unsigned DEF_FRAC_BITS = 15;

  // WAIT_SYNC: waiting for a tap-0 marker; RUN: locked to the frame phase.
  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_e;

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift followed by clamp to a narrower signed range.
module sat_shift #(
  parameter int unsigned IN_W  = 40,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [IN_W-1:0] shifted;
  logic [IN_W-OUT_W:0]    head;

  // Result fits only when every bit above the output sign bit matches it.
  always_comb begin
    shifted = din >>> SHIFT;
    head    = shifted[IN_W-1:OUT_W-1];
    if ((&head) || !(|head)) begin
      dout = shifted[OUT_W-1:0];
    end else if (head[IN_W-OUT_W]) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Two-stage multiply-accumulate for one FIR output frame, with frame-length
// checking against the phase decoder markers and saturated output.
module mac_accumulator
  import eq_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COEFF_W   = DEF_COEFF_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned TAPS      = DEF_TAPS,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_enable,
  input  logic                      phase_0,
  input  logic                      phase_63,
  input  logic signed [DATA_W-1:0]  sample_in,
  input  logic signed [COEFF_W-1:0] coeff_in,
  output logic signed [DATA_W-1:0]  filter_out,
  output logic                      out_valid,
  output logic                      frame_err
);

  localparam int unsigned PROD_W   = DATA_W + COEFF_W;
  localparam logic [6:0]  LAST_TAP = 7'(TAPS - 1);

  logic signed [PROD_W-1:0] prod_q;
  logic                     p0_q;
  logic                     p63_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [6:0]               tap_cnt_q;
  logic [6:0]               tap_cur;
  logic                     frame_ok;
  logic                     fire_out;
  logic                     fire_err;
  logic signed [DATA_W-1:0] sat_out;
  state_e                   state_q, state_d;

  // Stage 1: product and phase markers, aligned with each other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      p0_q   <= 1'b0;
      p63_q  <= 1'b0;
    end else if (clk_enable) begin
      prod_q <= PROD_W'(sample_in) * PROD_W'(coeff_in);
      p0_q   <= phase_0;
      p63_q  <= phase_63;
    end
  end

  // Tap index of the product now in stage 2; tap 0 when the frame restarts.
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    acc_sum  = acc_q + prod_ext;
    if (p0_q) begin
      tap_cur = 7'd0;
    end else if (tap_cnt_q == 7'd127) begin
      tap_cur = tap_cnt_q;
    end else begin
      tap_cur = tap_cnt_q + 7'd1;
    end
    // A coincident tap-0 marker always makes the frame invalid.
    frame_ok = !p0_q && (tap_cur == LAST_TAP);
  end

  // Stage 2: accumulator and tap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      tap_cnt_q <= '0;
    end else if (clk_enable) begin
      acc_q <= p0_q ? prod_ext : acc_sum;
      if (p0_q) begin
        tap_cnt_q <= 7'd0;
      end else if (state_q == RUN) begin
        tap_cnt_q <= tap_cur;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: sync on tap 0, drop sync on a bad frame length.
  always_comb begin
    state_d = state_q;
    if (clk_enable) begin
      unique case (state_q)
        WAIT_SYNC: if (p0_q) state_d = RUN;
        RUN:       if (p63_q && !frame_ok) state_d = WAIT_SYNC;
        default:   state_d = WAIT_SYNC;
      endcase
    end
  end

  // FSM outputs: end-of-frame markers only count while synced.
  always_comb begin
    fire_out = clk_enable && (state_q == RUN) && p63_q && frame_ok;
    fire_err = clk_enable && (state_q == RUN) && p63_q && !frame_ok;
  end

  // Output register; pulses self-clear on the next edge even when gated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filter_out <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid <= fire_out;
      frame_err <= fire_err;
      if (fire_out) begin
        filter_out <= sat_out;
      end
    end
  end

  sat_shift #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W),
    .SHIFT (FRAC_BITS)
  ) u_sat_shift (
    .din  (acc_sum),
    .dout (sat_out)
  );

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: stimulus pushes expected frame
// results, an independent monitor pops and compares on each output pulse.
module tb_mac_accumulator;

  logic               clk;
  logic               rst;
  logic               clk_enable;
  logic               phase_0;
  logic               phase_63;
  logic signed [15:0] sample_in;
  logic signed [15:0] coeff_in;
  logic signed [15:0] filter_out;
  logic               out_valid;
  logic               frame_err;

  typedef struct {
    int kind;   // 0 = out_valid, 1 = frame_err
    int val;    // expected filter_out
    int start;  // edge index that samples phase_0
    int lat;    // expected edges from start to the pulse
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   last_out = 0;

  mac_accumulator u_dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .phase_0    (phase_0),
    .phase_63   (phase_63),
    .sample_in  (sample_in),
    .coeff_in   (coeff_in),
    .filter_out (filter_out),
    .out_valid  (out_valid),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after every rising edge.
  initial begin : monitor
    exp_t e;
    int   kind;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid || frame_err) begin
        kind = (out_valid && frame_err) ? 2 : (frame_err ? 1 : 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", kind + 10, -1);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", kind, e.kind);
          check("filter_out", int'(filter_out), e.val);
          check("latency", cyc - e.start, e.lat);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clk_enable = 1'b1;
      phase_0    = 1'b0;
      phase_63   = 1'b0;
      sample_in  = '0;
      coeff_in   = '0;
    end
  endtask

  // Drive taps first..last; phase_63 on 'last' if end_frame. kind < 0 means
  // no output is expected. A gate of gate_len disabled cycles precedes gate_at.
  task automatic frame(input int first, input int last, input bit end_frame,
                       input int s, input int c, input int gate_at, input int gate_len,
                       input int kind, input int val);
    int start;
    start = 0;
    for (int i = first; i <= last; i++) begin
      if (i == gate_at) begin
        for (int g = 0; g < gate_len; g++) begin
          @(negedge clk);
          clk_enable = 1'b0;
        end
      end
      @(negedge clk);
      clk_enable = 1'b1;
      phase_0    = (i == 0);
      phase_63   = end_frame && (i == last);
      sample_in  = 16'(s);
      coeff_in   = 16'(c);
      if (i == 0) start = cyc + 1;
      if (end_frame && (i == last) && (kind >= 0)) begin
        sb.push_back('{kind: kind, val: val, start: start, lat: last + 1 + gate_len});
        if (kind == 0) last_out = val;
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    clk_enable = 1'b0;
    phase_0    = 1'b0;
    phase_63   = 1'b0;
    sample_in  = '0;
    coeff_in   = '0;
    #3;
    check("reset_filter_out", int'(filter_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);
    // Lone phase_63 while unsynced must be ignored.
    frame(5, 5, 1'b1, 1000, 16384, -1, 0, -1, 0);
    idle(3);

    frame(0, 63, 1'b1, 1000, 16384, -1, 0, 0, 32000);     // nominal
    frame(0, 63, 1'b1, 32767, 32767, -1, 0, 0, 32767);    // positive clamp
    frame(0, 63, 1'b1, -32768, 32767, -1, 0, 0, -32768);  // negative clamp
    frame(0, 63, 1'b1, 1000, 16384, 20, 5, 0, 32000);     // enable gap at tap 20
    frame(0, 10, 1'b1, 1000, 16384, -1, 0, 1, last_out);  // short frame
    frame(0, 63, 1'b1, -500, 8192, -1, 0, 0, -8000);
    frame(0, 0, 1'b1, 1000, 16384, -1, 0, 1, last_out);   // phase_0 with phase_63
    frame(0, 63, 1'b1, -1, 1, -1, 0, 0, -1);              // shift floors to -1
    frame(0, 63, 1'b1, 1, 1, -1, 0, 0, 0);

    // Reset at tap 30 drops the frame; its phase_63 must be ignored.
    frame(0, 29, 1'b0, 1000, 16384, -1, 0, -1, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_filter_out", int'(filter_out), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_frame_err", int'(frame_err), 0);
    last_out = 0;
    @(negedge clk);
    rst = 1'b1;
    frame(30, 63, 1'b1, 1000, 16384, -1, 0, -1, 0);
    frame(0, 63, 1'b1, 1000, 16384, -1, 0, 0, 32000);

    idle(8);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
